// File: rtl/port_grant_scheduler_if.sv
// Request/grant/credit bundle for one output port's scheduler.
// slave = scheduler side; master = requesters, merge and downstream buffer side.
interface port_grant_scheduler_if #(
  parameter int NREQ = 5,
  parameter int IDW  = 3,
  parameter int CW   = 3
);
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] ack;
  logic            grant_valid;
  logic            grant_ready;
  logic [IDW-1:0]  grant_id;
  logic [NREQ-1:0] grant_onehot;
  logic            credit_return;
  logic [CW-1:0]   credit_count;
  logic            err_credit;

  modport master (
    output req, grant_ready, credit_return,
    input  ack, grant_valid, grant_id, grant_onehot, credit_count, err_credit
  );

  modport slave (
    input  req, grant_ready, credit_return,
    output ack, grant_valid, grant_id, grant_onehot, credit_count, err_credit
  );
endinterface

// File: rtl/port_grant_scheduler.sv
// Round-robin control-token scheduler for one router output port, gated by downstream credits.
// Credit counter, gating and err_credit exist only when CREDIT_FC_EN is defined.
module port_grant_scheduler #(
  parameter int NREQ    = 5,
  parameter int IDW     = 3,
  parameter int CREDITS = 4,
  parameter int CW      = 3
) (
  input logic                 CLK,
  input logic                 RESET,
  port_grant_scheduler_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_q;
  logic [IDW-1:0]  ptr_q;
  logic [IDW-1:0]  grant_id_q;
  logic [NREQ-1:0] grant_onehot_q;
  logic            grant_valid_q;

  logic [IDW-1:0]  sel_id_d;
  logic [NREQ-1:0] sel_onehot_d;
  logic            sel_found_d;
  logic [IDW-1:0]  cand;
  logic            credit_ok;

  // Scan starts one past the last winner so the previous owner has lowest priority.
  always_comb begin
    sel_found_d = 1'b0;
    sel_id_d    = '0;
    cand        = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IDW'(NREQ - 1)) ? '0 : cand + IDW'(1);
      if (!sel_found_d && bus.req[cand]) begin
        sel_found_d = 1'b1;
        sel_id_d    = cand;
      end
    end
    sel_onehot_d = NREQ'(1) << sel_id_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q        <= IDLE;
      ptr_q          <= IDW'(NREQ - 1);
      grant_valid_q  <= 1'b0;
      grant_id_q     <= '0;
      grant_onehot_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found_d && credit_ok) begin
            grant_id_q     <= sel_id_d;
            grant_onehot_q <= sel_onehot_d;
            grant_valid_q  <= 1'b1;
            state_q        <= GRANT;
          end
        end
        GRANT: begin
          // The token is held until the merge takes it, even if req drops.
          if (bus.grant_ready) begin
            ptr_q         <= grant_id_q;
            grant_valid_q <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.grant_valid  = grant_valid_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.grant_onehot = grant_onehot_q;
  assign bus.ack          = (grant_valid_q && bus.grant_ready) ? grant_onehot_q : '0;

`ifdef CREDIT_FC_EN
  logic [CW-1:0] credit_q, credit_d;
  logic          err_q, err_d;
  logic          handshake;

  assign handshake = grant_valid_q & bus.grant_ready;

  // A return in the same cycle as a handshake cancels it out.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    if (handshake && !bus.credit_return) begin
      credit_d = credit_q - CW'(1);
    end else if (bus.credit_return && !handshake) begin
      if (credit_q == CW'(CREDITS)) err_d = 1'b1;
      else                          credit_d = credit_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      credit_q <= CW'(CREDITS);
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  assign credit_ok        = (credit_q != '0);
  assign bus.credit_count = credit_q;
  assign bus.err_credit   = err_q;
`else
  logic credit_return_unused;

  assign credit_return_unused = bus.credit_return;
  assign credit_ok            = 1'b1;
  assign bus.credit_count     = CW'(CREDITS);
  assign bus.err_credit       = 1'b0;
`endif
endmodule

// File: tb/tb_port_grant_scheduler.sv
// Bench for port_grant_scheduler: vector table, directed corner sequences and a
// random run against a transaction-level model of the round-robin/credit rules.
module tb_port_grant_scheduler;
  localparam int NREQ    = 5;
  localparam int IDW     = 3;
  localparam int CREDITS = 4;
  localparam int CW      = 3;
`ifdef CREDIT_FC_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  port_grant_scheduler_if #(.NREQ(NREQ), .IDW(IDW), .CW(CW)) bus ();

  port_grant_scheduler #(.NREQ(NREQ), .IDW(IDW), .CREDITS(CREDITS), .CW(CW)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // model: owner = source holding the token (-1 none), last = previous winner
  int m_owner, m_last, m_cred;
  bit m_err;

  logic            s_gv, s_err;
  logic [IDW-1:0]  s_id;
  logic [NREQ-1:0] s_ack, s_oh;
  logic [CW-1:0]   s_cnt;

  int got_id[$];
  int got_cyc[$];

  typedef struct {
    logic [NREQ-1:0] req;
    logic            rdy;
    logic            ret;
    logic            gv;
    logic [IDW-1:0]  id;
    logic [NREQ-1:0] ack;
    int              cnt;
  } vec_t;
  vec_t tbl[12];

  function automatic int cx(input int n);
    return FC ? n : CREDITS;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_cred  = CREDITS;
    m_err   = 1'b0;
  endfunction

  function automatic void model_step(input logic [NREQ-1:0] req, input logic rdy, input logic ret);
    bit hs, found;
    hs = (m_owner >= 0) && rdy;
    if (m_owner >= 0) begin
      if (rdy) begin
        m_last  = m_owner;
        m_owner = -1;
      end
    end else if (req != 0 && (!FC || m_cred > 0)) begin
      found = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
        if (!found && req[(m_last + k) % NREQ]) begin
          found   = 1'b1;
          m_owner = (m_last + k) % NREQ;
        end
      end
    end
    if (FC) begin
      if (hs && !ret) m_cred--;
      else if (ret && !hs) begin
        if (m_cred == CREDITS) m_err = 1'b1;
        else m_cred++;
      end
    end
  endfunction

  task automatic model_check(input string tag);
    chk({tag, ".gv"}, s_gv, m_owner >= 0);
    chk({tag, ".ack"}, s_ack, (m_owner >= 0 && bus.grant_ready) ? (1 << m_owner) : 0);
    if (m_owner >= 0) begin
      chk({tag, ".id"}, s_id, m_owner);
      chk({tag, ".oh"}, s_oh, 1 << m_owner);
    end
    chk({tag, ".cnt"}, s_cnt, FC ? m_cred : CREDITS);
    chk({tag, ".err"}, s_err, FC ? m_err : 1'b0);
  endtask

  // Sample on the falling edge, advance the model on the rising edge, return just after it.
  task automatic tick(input string tag);
    @(negedge CLK);
    s_gv  = bus.grant_valid;
    s_id  = bus.grant_id;
    s_oh  = bus.grant_onehot;
    s_ack = bus.ack;
    s_cnt = bus.credit_count;
    s_err = bus.err_credit;
    model_check(tag);
    @(posedge CLK);
    model_step(bus.req, bus.grant_ready, bus.credit_return);
    #1;
  endtask

  task automatic do_reset();
    bus.req           = '0;
    bus.grant_ready   = 1'b0;
    bus.credit_return = 1'b0;
    RESET = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, cx(4)};
    tbl[1]  = '{5'b10000, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, cx(4)};
    tbl[2]  = '{5'b10000, 1'b1, 1'b0, 1'b1, 3'd4, 5'b10000, cx(4)};
    tbl[3]  = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, cx(3)};
    tbl[4]  = '{5'b00110, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000, cx(3)};
    tbl[5]  = '{5'b00110, 1'b0, 1'b0, 1'b1, 3'd1, 5'b00000, cx(3)};
    tbl[6]  = '{5'b00110, 1'b0, 1'b0, 1'b1, 3'd1, 5'b00000, cx(3)};
    tbl[7]  = '{5'b00110, 1'b1, 1'b0, 1'b1, 3'd1, 5'b00010, cx(3)};
    tbl[8]  = '{5'b00100, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, cx(2)};
    tbl[9]  = '{5'b00100, 1'b1, 1'b1, 1'b1, 3'd2, 5'b00100, cx(2)};
    tbl[10] = '{5'b00000, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00000, cx(2)};
    tbl[11] = '{5'b00000, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00000, cx(3)};

    // reset values, then a quiet idle period
    do_reset();
    chk("rst.gv", bus.grant_valid, 0);
    chk("rst.id", bus.grant_id, 0);
    chk("rst.oh", bus.grant_onehot, 0);
    chk("rst.ack", bus.ack, 0);
    chk("rst.cnt", bus.credit_count, CREDITS);
    chk("rst.err", bus.err_credit, 0);
    for (int i = 0; i < 10; i++) begin
      tick("idle");
      chk("idle.gv", s_gv, 0);
      chk("idle.cnt", s_cnt, CREDITS);
    end

    for (int i = 0; i < 12; i++) begin
      bus.req           = tbl[i].req;
      bus.grant_ready   = tbl[i].rdy;
      bus.credit_return = tbl[i].ret;
      tick($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.vgv", i), s_gv, tbl[i].gv);
      chk($sformatf("tbl%0d.vack", i), s_ack, tbl[i].ack);
      chk($sformatf("tbl%0d.vcnt", i), s_cnt, tbl[i].cnt);
      if (tbl[i].gv) chk($sformatf("tbl%0d.vid", i), s_id, tbl[i].id);
    end

    // round-robin with everyone requesting, credit returned after each handshake
    do_reset();
    bus.req         = 5'b11111;
    bus.grant_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick("rr");
      bus.credit_return = (s_ack != 0);
      if (s_ack != 0) begin
        got_id.push_back(int'(s_id));
        got_cyc.push_back(c);
      end
    end
    chk("rr.count", got_id.size(), 6);
    for (int i = 0; i < 6 && i < got_id.size(); i++)
      chk($sformatf("rr.order%0d", i), got_id[i], i % NREQ);
    for (int i = 1; i < got_cyc.size(); i++)
      chk($sformatf("rr.gap%0d", i), got_cyc[i] - got_cyc[i-1], 2);

    // backpressure: token held stable while merge stalls
    do_reset();
    bus.req         = 5'b00110;
    bus.grant_ready = 1'b0;
    tick("bp");
    for (int i = 0; i < 6; i++) begin
      tick("bp");
      chk("bp.hold_gv", s_gv, 1);
      chk("bp.hold_id", s_id, 1);
    end
    bus.grant_ready = 1'b1;
    tick("bp");
    chk("bp.ack1", s_ack, 5'b00010);
    bus.req = 5'b00100;
    tick("bp");
    tick("bp");
    chk("bp.next_id", s_id, 2);
    chk("bp.next_ack", s_ack, 5'b00100);

`ifdef CREDIT_FC_EN
    do_reset();
    bus.req         = 5'b11111;
    bus.grant_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick("ce");
    for (int i = 0; i < 3; i++) begin
      tick("ce");
      chk("ce.starved_gv", s_gv, 0);
      chk("ce.starved_cnt", s_cnt, 0);
    end
    bus.credit_return = 1'b1;
    tick("ce");
    chk("ce.pulse_gv", s_gv, 0);
    bus.credit_return = 1'b0;
    tick("ce");
    chk("ce.after1_gv", s_gv, 0);
    chk("ce.after1_cnt", s_cnt, 1);
    bus.credit_return = 1'b1;
    tick("ce");
    chk("ce.after2_gv", s_gv, 1);
    chk("ce.after2_id", s_id, 4);
    bus.credit_return = 1'b0;
    bus.req           = '0;
    tick("ce");
    chk("ce.simul_cnt", s_cnt, 1);
    for (int i = 0; i < 3; i++) begin
      bus.credit_return = 1'b1;
      tick("ce");
    end
    tick("ce");
    chk("ce.full_cnt", s_cnt, 4);
    chk("ce.full_err", s_err, 0);
    bus.credit_return = 1'b0;
    tick("ce");
    chk("ce.over_err", s_err, 1);
    chk("ce.over_cnt", s_cnt, 4);
    for (int i = 0; i < 3; i++) tick("ce");
    chk("ce.sticky_err", s_err, 1);
`else
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.credit_return = 1'b1;
      tick("nofc");
      chk("nofc.cnt", s_cnt, CREDITS);
      chk("nofc.err", s_err, 0);
    end
    bus.credit_return = 1'b0;
`endif

    // random traffic; a source's req is held until it sees its ack
    do_reset();
    for (int i = 0; i < 400; i++) begin
      tick("rnd");
      bus.req = bus.req & ~s_ack;
      if ($urandom_range(0, 2) == 0) bus.req = bus.req | NREQ'($urandom_range(0, 31));
      bus.grant_ready   = ($urandom_range(0, 2) != 0);
      bus.credit_return = ((CREDITS - m_cred) > 0 && $urandom_range(0, 3) == 0)
                          || ($urandom_range(0, 99) == 0);
    end

    // reset while a grant is outstanding
    do_reset();
    bus.req         = 5'b01000;
    bus.grant_ready = 1'b1;
    tick("mg");
    tick("mg");
    bus.req         = 5'b00100;
    bus.grant_ready = 1'b0;
    tick("mg");
    tick("mg");
    chk("mg.pre_gv", s_gv, 1);
    bus.grant_ready = 1'b1;
    RESET = 1'b1;
    #1;
    chk("mg.async_gv", bus.grant_valid, 0);
    chk("mg.async_ack", bus.ack, 0);
    chk("mg.async_cnt", bus.credit_count, CREDITS);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    bus.req = 5'b11111;
    tick("mg");
    tick("mg");
    chk("mg.first_id", s_id, 0);
    chk("mg.first_ack", s_ack, 5'b00001);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
